// File: rtl/tri_pkg.sv
// Shared definitions for the rasterizer-to-fragment arbiter: pixel packet layout and FSM states.
package tri_pkg;

    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned VERT_W = 80;
    localparam int unsigned UV_W   = 21;

    // Packet layout, MSB first: {x, y, v2, v1, v0, u, v}
    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [VERT_W-1:0] v2;
        logic [VERT_W-1:0] v1;
        logic [VERT_W-1:0] v0;
        logic [UV_W-1:0]   u;
        logic [UV_W-1:0]   v;
    } pix_t;

    localparam int unsigned PIX_W = $bits(pix_t);
    localparam int unsigned X_MSB = PIX_W - 1;
    localparam int unsigned Y_MSB = PIX_W - X_W - 1;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        SERVE  = 2'd1,
        SETTLE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tri_pix_fifo.sv
// Synchronous FIFO holding tagged pixels; head is visible combinationally from the storage registers.
module tri_pix_fifo #(
    parameter int unsigned WIDTH = 300,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/tri_raster_arb.sv
// Round-robin burst arbiter sharing one fragment port between NUM_RAST rasterizers,
// with credit-style source handshake and a source-tagged output FIFO.
module tri_raster_arb
    import tri_pkg::*;
#(
    parameter int unsigned NUM_RAST   = 2,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_RAST-1:0]           req_i,
    output logic [NUM_RAST-1:0]           ready_pix_o,
    input  logic [NUM_RAST-1:0]           valid_pix_i,
    input  logic [NUM_RAST*PIX_W-1:0]     pix_data_i,
    output logic                          valid_pix_o,
    input  logic                          ready_pix_i,
    output logic [PIX_W-1:0]              pix_data_o,
    output logic [$clog2(NUM_RAST)-1:0]   src_id_o,
    output logic [31:0]                   pix_count_o,
    output logic                          proto_err_o
);

    localparam int unsigned ID_W    = $clog2(NUM_RAST);
    localparam int unsigned BURST_W = $clog2(MAX_BURST);
    localparam int unsigned FREE_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W   = PIX_W + ID_W;

    arb_state_e           state, state_nxt;
    logic [ID_W-1:0]      grant, grant_nxt;
    logic [ID_W-1:0]      ptr, ptr_nxt;
    logic [BURST_W-1:0]   burst, burst_nxt, burst_inc;
    logic [NUM_RAST-1:0]  ready_q;
    logic                 armed;

    logic                 acc;
    logic [ID_W-1:0]      acc_id;
    logic [PIX_W-1:0]     acc_data;
    logic                 viol;
    logic                 found;
    logic [ID_W-1:0]      pick;
    logic [ID_W-1:0]      idx;

    logic [ENT_W-1:0]     head;
    logic                 empty;
    logic [FREE_W-1:0]    free;
    logic                 pop;

    // Accept only pulses that follow a credit; the cycle right after reset ignores everything.
    always_comb begin
        acc      = 1'b0;
        acc_id   = '0;
        acc_data = '0;
        for (int unsigned i = 0; i < NUM_RAST; i++) begin
            if (valid_pix_i[i] && ready_q[i]) begin
                acc      = armed;
                acc_id   = ID_W'(i);
                acc_data = pix_data_i[i*PIX_W +: PIX_W];
            end
        end
        viol = armed && (((valid_pix_i & ~ready_q) != '0) ||
                         ((valid_pix_i & (valid_pix_i - NUM_RAST'(1))) != '0));
    end

    // First requester strictly after the round-robin pointer, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_RAST; k++) begin
            idx = ID_W'((32'(ptr) + k) % NUM_RAST);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign burst_inc = burst + BURST_W'(1);

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        burst_nxt   = burst;
        ready_pix_o = '0;
        case (state)
            ARB: begin
                if (found) begin
                    grant_nxt = pick;
                    ptr_nxt   = pick;
                    burst_nxt = '0;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                // One free slot stays reserved for the pixel already in flight.
                ready_pix_o[grant] = req_i[grant] && (free >= FREE_W'(2));
                if (acc) burst_nxt = burst_inc;
                if (!req_i[grant] || (acc && (burst_inc == BURST_W'(MAX_BURST - 1))))
                    state_nxt = SETTLE;
            end
            SETTLE: state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ARB;
            grant       <= '0;
            ptr         <= ID_W'(NUM_RAST - 1);
            burst       <= '0;
            ready_q     <= '0;
            armed       <= 1'b0;
            proto_err_o <= 1'b0;
            pix_count_o <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            burst   <= burst_nxt;
            ready_q <= ready_pix_o;
            armed   <= 1'b1;
            if (viol) proto_err_o <= 1'b1;
            if (pop)  pix_count_o <= pix_count_o + 32'd1;
        end
    end

    tri_pix_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (reset_i),
        .push      (acc),
        .push_data ({acc_id, acc_data}),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .free      (free)
    );

    assign valid_pix_o = !empty;
    assign pop         = valid_pix_o && ready_pix_i;
    assign pix_data_o  = empty ? '0 : head[PIX_W-1:0];
    assign src_id_o    = empty ? '0 : head[ENT_W-1:PIX_W];

endmodule

// File: tb/tb_tri_raster_arb.sv
// Directed bench for tri_raster_arb: cycle table for the basic handshake, then
// scoreboarded streaming sequences for bursts, backpressure, req drop, violations and reset.
module tb_tri_raster_arb;
    import tri_pkg::*;

    localparam int unsigned NR = 2;

    logic                 clk;
    logic                 reset_i;
    logic [NR-1:0]        req_i;
    logic [NR-1:0]        ready_pix_o;
    logic [NR-1:0]        valid_pix_i;
    logic [NR*PIX_W-1:0]  pix_data_i;
    logic                 valid_pix_o;
    logic                 ready_pix_i;
    logic [PIX_W-1:0]     pix_data_o;
    logic [0:0]           src_id_o;
    logic [31:0]          pix_count_o;
    logic                 proto_err_o;

    tri_raster_arb #(.NUM_RAST(NR), .MAX_BURST(16), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .ready_pix_o (ready_pix_o),
        .valid_pix_i (valid_pix_i),
        .pix_data_i  (pix_data_i),
        .valid_pix_o (valid_pix_o),
        .ready_pix_i (ready_pix_i),
        .pix_data_o  (pix_data_o),
        .src_id_o    (src_id_o),
        .pix_count_o (pix_count_o),
        .proto_err_o (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [0:0] src;
        pix_t       data;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  vld;
        logic        dn;
        logic [1:0]  e_rdy;
        logic        e_vout;
        logic [8:0]  e_x;
        logic [7:0]  e_y;
        logic        e_src;
        logic [31:0] e_cnt;
    } vec_t;

    exp_t          exp_q[$];
    int            total;
    int            bad;
    logic [NR-1:0] rdy_seen;
    logic [NR-1:0] stream_en;
    logic [NR-1:0] inject;
    logic          err_seen;
    bit            auto_src;
    int            sent[NR];
    int            deliv[NR];
    int            seqn[NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_pix(input string name, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pix_t make_pix(input int src, input int n);
        pix_t p;
        p    = '0;
        p.x  = 9'(n);
        p.y  = 8'(src);
        p.v0 = {16{5'(n)}};
        p.v1 = 80'(n * 7919 + src);
        p.v2 = ~p.v1;
        p.u  = 21'(n * 3);
        p.v  = 21'(src + 1);
        return p;
    endfunction

    // One clock: observe this cycle at negedge, then drive the next cycle's source pulses.
    task automatic cycle();
        exp_t e;
        pix_t p;
        @(negedge clk);
        rdy_seen = ready_pix_o;
        err_seen = proto_err_o;
        if (valid_pix_o && ready_pix_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, src_id_o, pix_data_o[31:0]}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_src", 64'(src_id_o), 64'(e.src));
                chk_pix("out_data", pix_data_o, e.data);
            end
            deliv[src_id_o]++;
        end
        @(posedge clk);
        #1;
        if (auto_src) begin
            valid_pix_i = (rdy_seen & stream_en) | inject;
            for (int i = 0; i < NR; i++) begin
                if (rdy_seen[i] && stream_en[i]) begin
                    p = make_pix(i, seqn[i]);
                    pix_data_i[i*PIX_W +: PIX_W] = p;
                    e.src  = 1'(i);
                    e.data = p;
                    exp_q.push_back(e);
                    seqn[i]++;
                    sent[i]++;
                end
            end
        end
    endtask

    task automatic drain();
        req_i       = '0;
        stream_en   = '0;
        ready_pix_i = 1'b1;
        for (int k = 0; k < 24; k++) cycle();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_vout", 64'(valid_pix_o), 64'd0);
    endtask

    vec_t tv[11];

    initial begin
        int c0, s0, d0, nrdy, runs_len[$], gaps[$], len, gap;
        logic [1:0] runs_src[$];
        logic [1:0] cur, first_after;
        bit dropped;
        pix_t pa, pb;

        total = 0; bad = 0;
        auto_src = 0; stream_en = '0; inject = '0; rdy_seen = '0; err_seen = 0;
        for (int i = 0; i < NR; i++) begin sent[i] = 0; deliv[i] = 0; seqn[i] = 0; end

        //                req    vld   dn    e_rdy  vout  x     y     src   cnt
        tv[0]  = '{2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 9'd0, 8'd0, 1'b0, 32'd0};
        tv[1]  = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 9'd0, 8'd0, 1'b0, 32'd0};
        tv[2]  = '{2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 9'd0, 8'd0, 1'b0, 32'd0};
        tv[3]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 9'd5, 8'd7, 1'b0, 32'd0};
        tv[4]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 9'd0, 8'd0, 1'b0, 32'd1};
        tv[5]  = '{2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 9'd0, 8'd0, 1'b0, 32'd1};
        tv[6]  = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 9'd0, 8'd0, 1'b0, 32'd1};
        tv[7]  = '{2'b10, 2'b10, 1'b1, 2'b10, 1'b0, 9'd0, 8'd0, 1'b0, 32'd1};
        tv[8]  = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 9'd9, 8'd3, 1'b1, 32'd1};
        tv[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 9'd9, 8'd3, 1'b1, 32'd1};
        tv[10] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 9'd0, 8'd0, 1'b0, 32'd2};

        reset_i = 1'b1; req_i = '0; valid_pix_i = '0; ready_pix_i = 1'b0;
        pa = '0; pa.x = 9'd5; pa.y = 8'd7;
        pb = '0; pb.x = 9'd9; pb.y = 8'd3;
        pix_data_i = {pb, pa};
        #3;
        chk("rst_vout", 64'(valid_pix_o), 64'd0);
        chk("rst_ready", 64'(ready_pix_o), 64'd0);
        chk("rst_count", 64'(pix_count_o), 64'd0);
        chk("rst_err", 64'(proto_err_o), 64'd0);
        chk("rst_data", 64'(pix_data_o[63:0]), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Basic handshake, latency and stall stability
        for (int k = 0; k < 11; k++) begin
            req_i = tv[k].req; valid_pix_i = tv[k].vld; ready_pix_i = tv[k].dn;
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 64'(ready_pix_o), 64'(tv[k].e_rdy));
            chk($sformatf("v%0d_vout", k), 64'(valid_pix_o), 64'(tv[k].e_vout));
            chk($sformatf("v%0d_count", k), 64'(pix_count_o), 64'(tv[k].e_cnt));
            if (tv[k].e_vout) begin
                chk($sformatf("v%0d_x", k), 64'(pix_data_o[X_MSB -: X_W]), 64'(tv[k].e_x));
                chk($sformatf("v%0d_y", k), 64'(pix_data_o[Y_MSB -: Y_W]), 64'(tv[k].e_y));
                chk($sformatf("v%0d_src", k), 64'(src_id_o), 64'(tv[k].e_src));
            end
            @(posedge clk); #1;
        end
        valid_pix_i = '0;
        auto_src = 1;

        // Burst limit: both sources stream, 16-credit bursts alternate with a SETTLE+ARB gap
        req_i = 2'b11; stream_en = 2'b11; ready_pix_i = 1'b1;
        len = 0; gap = 0; cur = '0;
        for (int k = 0; k < 90; k++) begin
            cycle();
            if (rdy_seen == '0) begin
                if (len > 0) begin runs_src.push_back(cur); runs_len.push_back(len); len = 0; gap = 0; end
                gap++;
            end else begin
                if (len > 0 && rdy_seen != cur) begin
                    runs_src.push_back(cur); runs_len.push_back(len); len = 0; gap = 0;
                end
                if (len == 0) begin
                    if (runs_src.size() > 0) gaps.push_back(gap);
                    cur = rdy_seen;
                end
                len++;
            end
        end
        chk("burst_runs", 64'(runs_src.size() >= 4), 64'd1);
        for (int r = 0; r < 4 && r < runs_src.size(); r++) begin
            chk($sformatf("burst%0d_src", r), 64'(runs_src[r]), (r % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("burst%0d_len", r), 64'(runs_len[r]), 64'd16);
        end
        for (int r = 0; r < 3 && r < gaps.size(); r++)
            chk($sformatf("gap%0d", r), 64'(gaps[r]), 64'd2);
        drain();

        // Backpressure: only four pixels fit, including the one in flight
        c0 = int'(pix_count_o); s0 = sent[0]; nrdy = 0;
        ready_pix_i = 1'b0; req_i = 2'b01; stream_en = 2'b01;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (rdy_seen != '0) nrdy++;
        end
        chk("bp_ready_cycles", 64'(nrdy), 64'd4);
        chk("bp_accepted", 64'(sent[0] - s0), 64'd4);
        chk("bp_vout", 64'(valid_pix_o), 64'd1);
        chk("bp_src", 64'(src_id_o), 64'd0);
        if (exp_q.size() > 0) chk_pix("bp_head_stable", pix_data_o, exp_q[0].data);
        drain();
        chk("bp_count", 64'(int'(pix_count_o) - c0), 64'd4);

        // Req drop mid-burst: source 0 sends its last pixel as it drops req
        s0 = sent[0]; d0 = deliv[0]; nrdy = 0; dropped = 0; first_after = '0;
        req_i = 2'b01; stream_en = 2'b01; ready_pix_i = 1'b1;
        cycle();
        req_i = 2'b11; stream_en = 2'b11;
        for (int k = 0; k < 30; k++) begin
            if (rdy_seen[0] && !dropped) nrdy++;
            if (dropped && rdy_seen != '0 && first_after == '0) first_after = rdy_seen;
            if (!dropped && (sent[0] - s0) == 4) begin
                req_i[0] = 1'b0; stream_en[0] = 1'b0; dropped = 1;
            end
            cycle();
        end
        chk("drop_ready_cycles", 64'(nrdy), 64'd4);
        chk("drop_sent", 64'(sent[0] - s0), 64'd4);
        chk("drop_next_grant", 64'(first_after), 64'd2);
        drain();
        chk("drop_delivered", 64'(deliv[0] - d0), 64'd4);

        // Protocol violation: stray pulse from the non-granted source
        chk("pre_viol_err", 64'(proto_err_o), 64'd0);
        c0 = int'(pix_count_o); s0 = sent[0];
        req_i = 2'b01; stream_en = 2'b01;
        for (int k = 0; k < 6; k++) cycle();
        stream_en = 2'b00;
        inject = 2'b10;
        cycle();
        inject = 2'b00;
        cycle();
        chk("viol_err_same", 64'(err_seen), 64'd0);
        cycle();
        chk("viol_err_next", 64'(err_seen), 64'd1);
        cycle(); cycle();
        chk("viol_err_sticky", 64'(err_seen), 64'd1);
        drain();
        chk("viol_count", 64'(int'(pix_count_o) - c0), 64'(sent[0] - s0));

        // Asynchronous reset in the middle of a burst
        req_i = 2'b11; stream_en = 2'b11;
        for (int k = 0; k < 8; k++) cycle();
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_vout", 64'(valid_pix_o), 64'd0);
        chk("arst_ready", 64'(ready_pix_o), 64'd0);
        chk("arst_count", 64'(pix_count_o), 64'd0);
        chk("arst_err", 64'(proto_err_o), 64'd0);
        chk("arst_src", 64'(src_id_o), 64'd0);
        chk("arst_data", 64'(pix_data_o[63:0]), 64'd0);
        exp_q.delete();
        valid_pix_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        valid_pix_i = 2'b01;
        rdy_seen = '0;
        c0 = deliv[0] + deliv[1];
        cycle();
        chk("post_rst_ready0", 64'(rdy_seen), 64'd0);
        cycle();
        chk("post_rst_grant", 64'(rdy_seen), 64'd1);
        chk("post_rst_err", 64'(err_seen), 64'd0);
        for (int k = 0; k < 10; k++) cycle();
        drain();
        chk("post_rst_count", 64'(pix_count_o), 64'(deliv[0] + deliv[1] - c0));
        chk("post_rst_err_end", 64'(proto_err_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
